// File: rtl/e_clk_window_pkg.sv
// Shared types and helpers for the E-clock enable window generator.
package e_clk_window_pkg;

  localparam int CNT_W_DEF = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    ACTIVE = 3'd2,
    CAPPED = 3'd3,
    HOLD   = 3'd4
  } ch_state_e;

  // A zero-width counter is illegal, so a disabled watchdog still gets one bit.
  function automatic int wd_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/e_clk_window_ch.sv
// One enable channel: arm delay after E rise, optional width cap, hold after E fall.
// state  | meaning
// IDLE   | waiting for E rise
// ARM    | counting assert delay A while E is high
// ACTIVE | enable high, optionally counting down width W
// CAPPED | width cap reached, enable low until E falls
// HOLD   | enable held high for H cycles after E fall
module e_clk_window_ch
  import e_clk_window_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rise_i,
  input  logic             fall_i,
  input  logic             kill_i,
  input  logic [CNT_W-1:0] assert_dly_i,
  input  logic [CNT_W-1:0] max_width_i,
  input  logic [CNT_W-1:0] hold_dly_i,
  output logic             en_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] w_q, w_d;
  logic             en_q, en_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    if (kill_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise_i) begin
            state_d = ARM;
            cnt_d   = assert_dly_i;
          end
        end
        ARM: begin
          if (fall_i) begin
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            state_d = ACTIVE;
            cnt_d   = max_width_i;
            w_d     = max_width_i;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ACTIVE, CAPPED: begin
          if (fall_i) begin
            if (hold_dly_i == '0) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = HOLD;
              cnt_d   = hold_dly_i;
            end
          end else if (state_q == ACTIVE && w_q != '0) begin
            if (cnt_q == CNT_W'(1)) state_d = CAPPED;
            cnt_d = cnt_q - 1'b1;
          end
        end
        HOLD: begin
          // A new E rise truncates the hold and starts the next window.
          if (rise_i) begin
            state_d = ARM;
            cnt_d   = assert_dly_i;
          end else if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    en_d = (state_d == ACTIVE) || (state_d == HOLD);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      en_q    <= en_d;
    end
  end

  assign en_o = en_q;

endmodule

// File: rtl/e_clk_window_gen.sv
// E-clock edge detect, stopped-clock watchdog and NUM_CH enable window channels.
// Define EWIN_SYNC_EN to put a 2-flop synchroniser in front of the edge detector.
module e_clk_window_gen
  import e_clk_window_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 1023
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_e_clk,
  input  logic [NUM_CH*CNT_W-1:0] i_assert_dly,
  input  logic [NUM_CH*CNT_W-1:0] i_max_width,
  input  logic [NUM_CH*CNT_W-1:0] i_hold_dly,
  output logic [NUM_CH-1:0]       o_en,
  output logic                    o_e_rise,
  output logic                    o_e_fall,
  output logic                    o_e_lost
);

  localparam int              WD_W   = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  logic e_s;
`ifdef EWIN_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge i_clk) begin
    if (!i_reset) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], i_e_clk};
  end
  assign e_s = sync_q[1];
`else
  assign e_s = i_e_clk;
`endif

  logic            e_d_q;
  logic            rise, fall, e_edge, kill;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            lost_q, lost_d;

  assign rise   = e_s & ~e_d_q;
  assign fall   = ~e_s & e_d_q;
  assign e_edge = rise | fall;

  always_comb begin
    wd_d   = wd_q;
    lost_d = lost_q;
    if (e_edge)              wd_d = '0;
    else if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
    // Once lost, only a rise recovers; that rise is swallowed by kill below.
    if (lost_q) lost_d = ~rise;
    else        lost_d = (TIMEOUT != 0) && (wd_d == WD_MAX);
  end

  assign kill = lost_q | lost_d;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      e_d_q  <= 1'b0;
      wd_q   <= '0;
      lost_q <= 1'b0;
    end else begin
      e_d_q  <= e_s;
      wd_q   <= wd_d;
      lost_q <= lost_d;
    end
  end

  assign o_e_rise = rise & i_reset;
  assign o_e_fall = fall & i_reset;
  assign o_e_lost = lost_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    e_clk_window_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_i        (i_clk),
      .rst_ni       (i_reset),
      .rise_i       (rise),
      .fall_i       (fall),
      .kill_i       (kill),
      .assert_dly_i (i_assert_dly[c*CNT_W +: CNT_W]),
      .max_width_i  (i_max_width[c*CNT_W +: CNT_W]),
      .hold_dly_i   (i_hold_dly[c*CNT_W +: CNT_W]),
      .en_o         (o_en[c])
    );
  end

endmodule

// File: tb/tb_e_clk_window_gen.sv
// Self-checking bench for e_clk_window_gen: directed scenarios plus a randomized E/config run.
module tb_e_clk_window_gen;

  localparam int NCH  = 2;
  localparam int CW   = 7;
  localparam int TO   = 200;
  localparam int NCYC = 1500;
`ifdef EWIN_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic              clk, rst_n, e;
  logic [NCH*CW-1:0] adly, wmax, hdly;
  logic [NCH-1:0]    en;
  logic              rise, fall, lost;
  int                n_tests, n_fail;

  logic eh [0:2047];
  int   ah [0:NCH-1][0:2047];
  int   wh [0:NCH-1][0:2047];
  int   hh [0:NCH-1][0:2047];

  e_clk_window_gen #(.NUM_CH(NCH), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_e_clk(e),
    .i_assert_dly(adly), .i_max_width(wmax), .i_hold_dly(hdly),
    .o_en(en), .o_e_rise(rise), .o_e_fall(fall), .o_e_lost(lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL tb_timeout simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_ch(input int c, input int a, input int w, input int h);
    adly[c*CW +: CW] = CW'(a);
    wmax[c*CW +: CW] = CW'(w);
    hdly[c*CW +: CW] = CW'(h);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    e     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step(input logic ev);
    @(posedge clk); #1;
    e = ev;
    @(negedge clk);
  endtask

  // E as seen by the edge detector in cycle n of the random run.
  function automatic logic ee(input int n);
    if (n - SL < 0) return 1'b0;
    return eh[n-SL];
  endfunction

  function automatic logic rise_at(input int n);
    return ee(n) & ~ee(n-1);
  endfunction

  function automatic logic fall_at(input int n);
    return ~ee(n) & ee(n-1);
  endfunction

  // Enable from event times: last rise T, first fall F after T, latched A/W/H.
  function automatic logic model_en(input int c, input int n);
    int t, f, a, w, h;
    t = -1;
    f = -1;
    for (int k = n - 1; k >= 0; k--) if (rise_at(k)) begin t = k; break; end
    if (t < 0) return 1'b0;
    for (int k = t + 1; k <= n - 1; k++) if (fall_at(k)) begin f = k; break; end
    a = ah[c][t];
    if (f < 0) begin
      if (n < t + 2 + a) return 1'b0;
      w = wh[c][t+1+a];
      return (w == 0) || (n <= t + 1 + a + w);
    end
    if (f <= t + 1 + a) return 1'b0;
    h = hh[c][f];
    return n <= f + h;
  endfunction

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    e     = 1'b1;
    set_ch(0, 3, 5, 2);
    set_ch(1, 0, 0, 4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (en !== 2'b00)  begin n_fail++; $display("FAIL reset_en got=%b exp=00", en); end
    n_tests++; if (rise !== 1'b0) begin n_fail++; $display("FAIL reset_rise got=%b exp=0", rise); end
    n_tests++; if (fall !== 1'b0) begin n_fail++; $display("FAIL reset_fall got=%b exp=0", fall); end
    n_tests++; if (lost !== 1'b0) begin n_fail++; $display("FAIL reset_lost got=%b exp=0", lost); end
  endtask

  task automatic test_basic();
    apply_reset();
    set_ch(0, 3, 0, 2);
    set_ch(1, 0, 44, 4);
    for (int i = 0; i < 200 + SL; i++) begin
      int k, p;
      logic [1:0] xe;
      logic xr, xf;
      step((i < 200) && ((i % 100) < 50));
      k  = i - SL;
      xe = 2'b00; xr = 1'b0; xf = 1'b0;
      if (k >= 0) begin
        p     = k % 100;
        xe[0] = (p >= 5) && (p <= 52);
        xe[1] = ((p >= 2) && (p <= 45)) || ((p >= 51) && (p <= 54));
        xr    = (p == 0);
        xf    = (p == 50);
      end
      n_tests++; if (en !== xe)   begin n_fail++; $display("FAIL basic_en k=%0d got=%b exp=%b", k, en, xe); end
      n_tests++; if (rise !== xr) begin n_fail++; $display("FAIL basic_rise k=%0d got=%b exp=%b", k, rise, xr); end
      n_tests++; if (fall !== xf) begin n_fail++; $display("FAIL basic_fall k=%0d got=%b exp=%b", k, fall, xf); end
    end
  endtask

  task automatic test_short_pulse();
    apply_reset();
    set_ch(0, 5, 0, 3);
    set_ch(1, 0, 0, 0);
    for (int i = 0; i < 50 + SL; i++) begin
      int k;
      logic [1:0] xe;
      step((i < 3) || ((i >= 20) && (i < 40)));
      k     = i - SL;
      xe[0] = (k >= 27) && (k <= 43);
      xe[1] = (k == 2) || (k == 3) || ((k >= 22) && (k <= 40));
      n_tests++; if (en !== xe) begin n_fail++; $display("FAIL short_en k=%0d got=%b exp=%b", k, en, xe); end
    end
  endtask

  task automatic test_hold_restart();
    apply_reset();
    set_ch(0, 3, 0, 6);
    set_ch(1, 0, 0, 0);
    for (int i = 0; i < 55 + SL; i++) begin
      int k;
      logic [1:0] xe;
      logic xr;
      step((i < 20) || ((i >= 22) && (i < 40)));
      k     = i - SL;
      xe[0] = ((k >= 5) && (k <= 22)) || ((k >= 27) && (k <= 46));
      xe[1] = ((k >= 2) && (k <= 20)) || ((k >= 24) && (k <= 40));
      xr    = (k == 0) || (k == 22);
      n_tests++; if (en !== xe)   begin n_fail++; $display("FAIL hold_en k=%0d got=%b exp=%b", k, en, xe); end
      n_tests++; if (rise !== xr) begin n_fail++; $display("FAIL hold_rise k=%0d got=%b exp=%b", k, rise, xr); end
    end
  endtask

  task automatic test_watchdog();
    apply_reset();
    set_ch(0, 2, 0, 3);
    set_ch(1, 0, 0, 0);
    for (int i = 0; i < 271 + SL; i++) begin
      int k;
      logic [1:0] xe;
      logic xl;
      step((i < 215) || ((i >= 230) && (i < 240)) || (i >= 260));
      k     = i - SL;
      xl    = (k >= TO + 1) && (k <= 230);
      xe[0] = ((k >= 4) && (k <= TO)) || (k >= 264);
      xe[1] = ((k >= 2) && (k <= TO)) || (k >= 262);
      n_tests++; if (lost !== xl) begin n_fail++; $display("FAIL wd_lost k=%0d got=%b exp=%b", k, lost, xl); end
      n_tests++; if (en !== xe)   begin n_fail++; $display("FAIL wd_en k=%0d got=%b exp=%b", k, en, xe); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_ch(0, 0, 0, 5);
    set_ch(1, 0, 0, 5);
    for (int i = 0; i < 12; i++) step(1'b1);
    n_tests++; if (en !== 2'b11) begin n_fail++; $display("FAIL rmid_pre_en got=%b exp=11", en); end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (en !== 2'b00)  begin n_fail++; $display("FAIL rmid_en got=%b exp=00", en); end
    n_tests++; if (rise !== 1'b0) begin n_fail++; $display("FAIL rmid_rise got=%b exp=0", rise); end
    n_tests++; if (fall !== 1'b0) begin n_fail++; $display("FAIL rmid_fall got=%b exp=0", fall); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      logic [1:0] xe;
      logic xr;
      if (j > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      xr = (j == SL);
      xe = (j >= SL + 2) ? 2'b11 : 2'b00;
      n_tests++; if (rise !== xr) begin n_fail++; $display("FAIL rrel_rise j=%0d got=%b exp=%b", j, rise, xr); end
      n_tests++; if (en !== xe)   begin n_fail++; $display("FAIL rrel_en j=%0d got=%b exp=%b", j, en, xe); end
    end
  endtask

  task automatic test_random();
    int   left;
    logic lvl;
    apply_reset();
    for (int c = 0; c < NCH; c++) set_ch(c, 2, 0, 1);
    lvl  = 1'b0;
    left = 5;
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk); #1;
      if (left == 0) begin
        lvl  = ~lvl;
        left = $urandom_range(1, 30);
      end
      left--;
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 15) == 0)
          set_ch(c, $urandom_range(0, 10),
                 ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 25),
                 $urandom_range(0, 6));
        ah[c][n] = int'(adly[c*CW +: CW]);
        wh[c][n] = int'(wmax[c*CW +: CW]);
        hh[c][n] = int'(hdly[c*CW +: CW]);
      end
      e     = lvl;
      eh[n] = lvl;
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        logic xe;
        xe = model_en(c, n);
        n_tests++;
        if (en[c] !== xe) begin
          n_fail++;
          $display("FAIL rand_en ch=%0d n=%0d got=%b exp=%b", c, n, en[c], xe);
        end
      end
      n_tests++; if (rise !== rise_at(n)) begin n_fail++; $display("FAIL rand_rise n=%0d got=%b exp=%b", n, rise, rise_at(n)); end
      n_tests++; if (fall !== fall_at(n)) begin n_fail++; $display("FAIL rand_fall n=%0d got=%b exp=%b", n, fall, fall_at(n)); end
      n_tests++; if (lost !== 1'b0)       begin n_fail++; $display("FAIL rand_lost n=%0d got=%b exp=0", n, lost); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    e       = 1'b0;
    adly    = '0;
    wmax    = '0;
    hdly    = '0;
    test_reset();
    test_basic();
    test_short_pulse();
    test_hold_restart();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
